// File: rtl/vc_flit_arbiter_pkg.sv
// Shared types for the VC flit arbiter: the flit format used by the router
// (type in the top bits, packet size next) plus the arbiter FSM encoding.
package vc_flit_arbiter_pkg;

  localparam int FlitWidth   = 34;
  localparam int FlitTpWidth = 2;
  localparam int PktSzWidth  = 8;
  localparam int NumVirtChn  = 2;
  localparam int VcWidth     = (NumVirtChn > 1) ? $clog2(NumVirtChn) : 1;

  typedef enum logic [FlitTpWidth-1:0] {
    HEAD_FLIT = 2'b00,
    BODY_FLIT = 2'b01,
    TAIL_FLIT = 2'b10
  } flit_type_t;

  typedef struct packed {
    flit_type_t                                     type_f;
    logic [PktSzWidth-1:0]                          pkt_size;
    logic [FlitWidth-FlitTpWidth-PktSzWidth-1:0]    data;
  } s_flit_head_data_t;

  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

endpackage

// File: rtl/vc_flit_arbiter_rr_picker.sv
// Combinational round-robin search: first requester at or above ptr_i,
// wrapping modulo N. Returns one-hot grant (zero if no request) and its index.
module vc_flit_arbiter_rr_picker #(
  parameter int N    = 2,
  parameter int IdxW = $clog2(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] idx_o
);

  always_comb begin
    int               c;
    logic [IdxW-1:0]  cand;
    logic             found;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      c = int'(ptr_i) + k;
      if (c >= N) c = c - N;
      cand = IdxW'(c);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/vc_flit_arbiter.sv
// Round-robin VC-to-link flit arbiter with wormhole locking and a one-entry
// registered output. Optional per-VC packet counters under VC_ARB_PKT_CNT_EN.
module vc_flit_arbiter
  import vc_flit_arbiter_pkg::*;
#(
  parameter  int NumVc = NumVirtChn,
  parameter  int Width = FlitWidth,
  localparam int VcW   = $clog2(NumVc)
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic [Width-1:0]      fdata_i [NumVc],
  input  logic [NumVc-1:0]      valid_i,
  output logic [NumVc-1:0]      ready_o,
  output logic [Width-1:0]      fdata_o,
  output logic [VcW-1:0]        vc_id_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  locked_o
`ifdef VC_ARB_PKT_CNT_EN
  ,
  output logic [NumVc-1:0][15:0] pkt_cnt_o
`endif
);

  arb_state_t             state_q, state_d;
  logic [VcW-1:0]         rr_q, rr_d, lock_q, lock_d;
  logic                   valid_q;
  logic [Width-1:0]       fdata_q;
  logic [VcW-1:0]         vcid_q;

  logic [NumVc-1:0]       pick_gnt, grant;
  logic [VcW-1:0]         pick_idx, gidx, gidx_nxt;
  logic                   out_free, xfer;
  logic [Width-1:0]       sel;
  flit_type_t             ftype;
  logic [PktSzWidth-1:0]  psz;

  vc_flit_arbiter_rr_picker #(.N(NumVc), .IdxW(VcW)) u_pick (
    .req_i (valid_i),
    .ptr_i (rr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx)
  );

  always_comb begin
    grant = '0;
    gidx  = pick_idx;
    if (state_q == ARB_LOCKED) begin
      gidx          = lock_q;
      grant[lock_q] = valid_i[lock_q];
    end else begin
      grant = pick_gnt;
    end
    out_free = ~valid_q | ready_i;
    ready_o  = out_free ? grant : '0;
    xfer     = |ready_o;
    sel      = fdata_i[gidx];
    ftype    = flit_type_t'(sel[Width-1 -: FlitTpWidth]);
    psz      = sel[Width-1-FlitTpWidth -: PktSzWidth];
    gidx_nxt = (gidx == VcW'(NumVc-1)) ? '0 : gidx + VcW'(1);
  end

  // Malformed flits (body/tail in IDLE, head in LOCKED) pass through without
  // touching the lock; the assertions below flag them.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    lock_d  = lock_q;
    if (xfer) begin
      case (state_q)
        ARB_IDLE: begin
          if (ftype == HEAD_FLIT && psz != '0) begin
            state_d = ARB_LOCKED;
            lock_d  = gidx;
          end else begin
            rr_d = gidx_nxt;
          end
        end
        ARB_LOCKED: begin
          if (ftype == TAIL_FLIT) begin
            state_d = ARB_IDLE;
            rr_d    = gidx_nxt;
          end
        end
        default: state_d = ARB_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= ARB_IDLE;
      rr_q    <= '0;
      lock_q  <= '0;
      valid_q <= 1'b0;
      fdata_q <= '0;
      vcid_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      lock_q  <= lock_d;
      if (xfer) begin
        valid_q <= 1'b1;
        fdata_q <= sel;
        vcid_q  <= gidx;
      end else if (ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign valid_o  = valid_q;
  assign fdata_o  = fdata_q;
  assign vc_id_o  = vcid_q;
  assign locked_o = (state_q == ARB_LOCKED);

`ifdef VC_ARB_PKT_CNT_EN
  logic [NumVc-1:0][15:0] cnt_q;
  logic                   pkt_done;

  assign pkt_done = xfer && (ftype == TAIL_FLIT || (ftype == HEAD_FLIT && psz == '0));

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cnt_q <= '0;
    end else if (pkt_done && cnt_q[gidx] != 16'hFFFF) begin
      cnt_q[gidx] <= cnt_q[gidx] + 16'd1;
    end
  end

  assign pkt_cnt_o = cnt_q;
`endif

`ifndef NO_ASSERTIONS
  a_gnt_onehot: assert property (@(posedge clk) disable iff (arst) $onehot0(ready_o));
  a_stall_hold: assert property (@(posedge clk) disable iff (arst)
    valid_o && !ready_i |=> valid_o && $stable(fdata_o) && $stable(vc_id_o));
  a_idle_head:  assert property (@(posedge clk) disable iff (arst)
    xfer && state_q == ARB_IDLE |-> ftype == HEAD_FLIT);
  a_lock_nohd:  assert property (@(posedge clk) disable iff (arst)
    xfer && state_q == ARB_LOCKED |-> ftype != HEAD_FLIT);
`endif

endmodule
